// File: rtl/md_unit.sv
// Iterative multiply/divide engine: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, valid/ready on both sides, flush and a divide-by-zero fast path.
//
// state  | meaning
// IDLE   | no operation, ready for operands
// BUSY   | iterating, one bit per cycle
// DONE   | result held until out_ready
module md_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             busy,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_res_hi;
  logic [WIDTH-1:0]   r_res_lo;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_accept;
  logic               w_zero_div;
  logic               w_last;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_top;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  assign w_accept   = in_valid & in_ready & ~flush;
  assign w_zero_div = op[1] & (src_b == '0);
  assign w_last     = (r_state == S_BUSY) && (r_cnt == CNT_W'(WIDTH-1));
  assign w_a_neg    = op[0] & src_a[WIDTH-1];
  assign w_b_neg    = op[0] & src_b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -src_a : src_a;
  assign w_b_mag    = w_b_neg ? -src_b : src_b;

  // Multiply: lower half of r_acc holds the remaining multiplier bits.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  // Divide: the shifted partial remainder needs WIDTH+1 bits; diff MSB is the borrow.
  assign w_div_top  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff = w_div_top - {1'b0, r_opnd};
  assign w_div_ge   = ~w_div_diff[WIDTH];

  always_comb begin
    w_acc_nxt = '0;
    if (r_is_div)
      w_acc_nxt = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_top[WIDTH-1:0]),
                   r_acc[WIDTH-2:0], w_div_ge};
    else
      w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
  end

  assign w_prod_fix = r_neg_lo ? -w_acc_nxt : w_acc_nxt;
  assign w_q_fix    = r_neg_lo ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
  assign w_r_fix    = r_neg_hi ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_zero_div ? S_DONE : S_BUSY;
      S_BUSY: if (w_last) w_state_nxt = S_DONE;
      S_DONE: begin
        if (w_accept)       w_state_nxt = w_zero_div ? S_DONE : S_BUSY;
        else if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_comb begin
    in_ready    = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    out_valid   = (r_state == S_DONE);
    busy        = (r_state == S_BUSY);
    div_by_zero = r_dbz;
    res_hi      = r_res_hi;
    res_lo      = r_res_lo;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dbz    <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
    end else begin
      if (flush)
        r_cnt <= '0;
      else if (r_state == S_BUSY)
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      else
        r_cnt <= '0;

      if (w_accept) begin
        r_is_div <= op[1];
        r_neg_lo <= w_a_neg ^ w_b_neg;
        r_neg_hi <= op[1] ? w_a_neg : (w_a_neg ^ w_b_neg);
        r_opnd   <= op[1] ? w_b_mag : w_a_mag;
        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
        if (w_zero_div) begin
          r_res_lo <= '1;
          r_res_hi <= src_a;
        end
      end else if (r_state == S_BUSY) begin
        r_acc <= w_acc_nxt;
        if (w_last) begin
          if (r_is_div) begin
            r_res_lo <= w_q_fix;
            r_res_hi <= w_r_fix;
          end else begin
            {r_res_hi, r_res_lo} <= w_prod_fix;
          end
        end
      end

      if (flush)
        r_dbz <= 1'b0;
      else if (w_accept)
        r_dbz <= w_zero_div;
      else if ((r_state == S_DONE) && out_ready)
        r_dbz <= 1'b0;
    end
  end

endmodule
